// File: rtl/i2s_receiver.sv
// I2S (Philips) receiver: synchronises BCLK/WS/SD into master_clk, deserialises
// MSB-first left/right words and presents them as a stereo pair with a valid strobe.
module i2s_receiver #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                           master_clk,
    input  logic                           rst,
    input  logic                           i2s_bclk,
    input  logic                           i2s_ws,
    input  logic                           i2s_sd,
    output logic signed [SAMPLE_WIDTH-1:0] left_sample,
    output logic signed [SAMPLE_WIDTH-1:0] right_sample,
    output logic                           sample_valid,
    output logic                           locked,
    output logic                           word_error
);

    localparam int CW = $clog2(SAMPLE_WIDTH + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t FULL = cnt_t'(SAMPLE_WIDTH);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   bclk_prev;
    logic                   bit_rise;
    logic                   ws_bit;
    logic                   sd_bit;

    state_t                   state, state_next;
    logic                     primed, primed_next;
    logic                     ws_prev, ws_prev_next;
    logic [SAMPLE_WIDTH-1:0]  shift_reg, shift_next;
    cnt_t                     bit_cnt, cnt_next;
    logic                     have_left, have_left_next;
    logic signed [SAMPLE_WIDTH-1:0] left_next, right_next;
    logic                     valid_next, err_next;

    logic                     room;
    logic [SAMPLE_WIDTH-1:0]  shifted;
    cnt_t                     captured;
    logic [SAMPLE_WIDTH-1:0]  word;

    // bit_rise, ws_bit and sd_bit are registered together so the sampled
    // WS/SD stay aligned with the edge pulse.
    always_ff @(posedge master_clk) begin
        if (!rst) begin
            bclk_sync <= '0;
            ws_sync   <= '0;
            sd_sync   <= '0;
            bclk_prev <= 1'b0;
            bit_rise  <= 1'b0;
            ws_bit    <= 1'b0;
            sd_bit    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            ws_sync   <= {ws_sync[SYNC_STAGES-2:0], i2s_ws};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], i2s_sd};
            bclk_prev <= bclk_sync[SYNC_STAGES-1];
            bit_rise  <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
            ws_bit    <= ws_sync[SYNC_STAGES-1];
            sd_bit    <= sd_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge master_clk) begin
        if (!rst) begin
            state        <= UNLOCKED;
            primed       <= 1'b0;
            ws_prev      <= 1'b0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            have_left    <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            word_error   <= 1'b0;
        end else begin
            state        <= state_next;
            primed       <= primed_next;
            ws_prev      <= ws_prev_next;
            shift_reg    <= shift_next;
            bit_cnt      <= cnt_next;
            have_left    <= have_left_next;
            left_sample  <= left_next;
            right_sample <= right_next;
            sample_valid <= valid_next;
            word_error   <= err_next;
        end
    end

    assign room     = bit_cnt < FULL;
    assign shifted  = room ? {shift_reg[SAMPLE_WIDTH-2:0], sd_bit} : shift_reg;
    assign captured = room ? bit_cnt + cnt_t'(1) : bit_cnt;
    // Short words are left-justified so the missing LSBs read as zero.
    assign word     = shifted << (FULL - captured);

    always_comb begin
        state_next     = state;
        primed_next    = primed;
        ws_prev_next   = ws_prev;
        shift_next     = shift_reg;
        cnt_next       = bit_cnt;
        have_left_next = have_left;
        left_next      = left_sample;
        right_next     = right_sample;
        valid_next     = 1'b0;
        err_next       = 1'b0;

        if (bit_rise) begin
            ws_prev_next = ws_bit;
            // The first edge after reset only establishes the WS reference,
            // so a reset taken while WS=1 is not mistaken for a transition.
            if (!primed) begin
                primed_next = 1'b1;
            end else if (ws_bit != ws_prev) begin
                shift_next = '0;
                cnt_next   = '0;
                if (state == UNLOCKED) begin
                    state_next = LOCKED;
                end else begin
                    err_next = (captured != FULL);
                    if (!ws_prev) begin
                        left_next      = $signed(word);
                        have_left_next = 1'b1;
                    end else begin
                        right_next = $signed(word);
                        if (have_left) begin
                            valid_next     = 1'b1;
                            have_left_next = 1'b0;
                        end
                    end
                end
            end else if (state == LOCKED) begin
                shift_next = shifted;
                cnt_next   = captured;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives an I2S transmitter model on
// BCLK/WS/SD and checks captured pairs, strobes and lock behaviour.
module tb_i2s_receiver;

    logic        master_clk = 1'b0;
    logic        rst = 1'b0;
    logic        i2s_bclk = 1'b0;
    logic        i2s_ws = 1'b0;
    logic        i2s_sd = 1'b0;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_valid;
    logic        locked;
    logic        word_error;

    int total = 0;
    int bad = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int half = 40;
    int v0;
    logic [15:0] got_l[$];
    logic [15:0] got_r[$];
    logic [15:0] exp_l[$];
    logic [15:0] exp_r[$];

    i2s_receiver #(
        .SAMPLE_WIDTH(16),
        .SYNC_STAGES (2)
    ) dut (
        .master_clk  (master_clk),
        .rst         (rst),
        .i2s_bclk    (i2s_bclk),
        .i2s_ws      (i2s_ws),
        .i2s_sd      (i2s_sd),
        .left_sample (left_sample),
        .right_sample(right_sample),
        .sample_valid(sample_valid),
        .locked      (locked),
        .word_error  (word_error)
    );

    always #5 master_clk = ~master_clk;

    always @(negedge master_clk) begin
        if (sample_valid) begin
            valid_cnt++;
            got_l.push_back(left_sample);
            got_r.push_back(right_sample);
        end
        if (word_error) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge master_clk);
    endtask

    task automatic align(input int p);
        @(negedge master_clk);
        #(p);
    endtask

    // Transmitter changes WS/SD with BCLK low; the receiver samples on the rise.
    task automatic send_bit(input logic w, input logic b);
        i2s_bclk = 1'b0;
        i2s_ws   = w;
        i2s_sd   = b;
        #(half);
        i2s_bclk = 1'b1;
        #(half);
    endtask

    // WS flips on the slot's last bit, one bit ahead of the next MSB.
    task automatic send_slot(input logic ch, input logic [31:0] data, input int nbits, input int slot);
        logic b;
        logic w;
        for (int i = 0; i < slot; i++) begin
            b = (i < nbits) ? data[nbits-1-i] : 1'b1;
            w = (i == slot - 1) ? ~ch : ch;
            send_bit(w, b);
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits, input int slot);
        send_slot(1'b0, l, nbits, slot);
        send_slot(1'b1, r, nbits, slot);
    endtask

    initial begin
        logic [15:0] rl;
        logic [15:0] rr;
        logic [15:0] pat;

        wait_clks(4);
        rst = 1'b1;
        wait_clks(1);
        check("reset_left",   {16'h0, left_sample},  32'h0);
        check("reset_right",  {16'h0, right_sample}, 32'h0);
        check("reset_valid",  {31'h0, sample_valid}, 32'h0);
        check("reset_locked", {31'h0, locked},       32'h0);
        check("reset_err",    {31'h0, word_error},   32'h0);

        // Three 16/16 frames: the first left word only locks.
        align(3);
        send_frame(32'h7FFF, 32'h8001, 16, 16);
        wait_clks(10);
        check("f1_locked",     {31'h0, locked},       32'h1);
        check("f1_no_valid",   valid_cnt,             32'd0);
        check("f1_left_disc",  {16'h0, left_sample},  32'h0);
        check("f1_right_only", {16'h0, right_sample}, 32'h8001);
        send_frame(32'h7FFF, 32'h8001, 16, 16);
        send_frame(32'h7FFF, 32'h8001, 16, 16);
        wait_clks(10);
        check("f3_valid_cnt", valid_cnt,             32'd2);
        check("f3_left",      {16'h0, left_sample},  32'h7FFF);
        check("f3_right",     {16'h0, right_sample}, 32'h8001);
        check("f3_err",       err_cnt,               32'd0);

        // 32-bit slots: trailing ones beyond 16 bits are dropped.
        v0 = valid_cnt;
        align(3);
        send_frame(32'hA5C3, 32'h3C5A, 16, 32);
        wait_clks(10);
        check("wide_left",  {16'h0, left_sample},  32'hA5C3);
        check("wide_right", {16'h0, right_sample}, 32'h3C5A);
        check("wide_valid", valid_cnt - v0,        32'd1);
        check("wide_err",   err_cnt,               32'd0);

        // 12-bit slots: left-justified and flagged.
        v0 = valid_cnt;
        align(3);
        send_frame(32'hABC, 32'h123, 12, 12);
        wait_clks(10);
        check("short_left",  {16'h0, left_sample},  32'hABC0);
        check("short_right", {16'h0, right_sample}, 32'h1230);
        check("short_err",   err_cnt,               32'd2);
        check("short_valid", valid_cnt - v0,        32'd1);

        // Reset in the middle of a left word.
        align(3);
        pat = 16'hFFFF;
        for (int i = 0; i < 8; i++) send_bit(1'b0, pat[15-i]);
        @(negedge master_clk);
        rst = 1'b0;
        @(negedge master_clk);
        rst = 1'b1;
        check("mid_rst_left",   {16'h0, left_sample},  32'h0);
        check("mid_rst_right",  {16'h0, right_sample}, 32'h0);
        check("mid_rst_locked", {31'h0, locked},       32'h0);
        check("mid_rst_valid",  {31'h0, sample_valid}, 32'h0);
        v0 = valid_cnt;
        align(3);
        send_frame(32'h1111, 32'h2222, 16, 16);
        wait_clks(10);
        check("post_rst_locked", {31'h0, locked},       32'h1);
        check("post_rst_nvalid", valid_cnt - v0,        32'd0);
        check("post_rst_left",   {16'h0, left_sample},  32'h0);
        check("post_rst_right",  {16'h0, right_sample}, 32'h2222);
        send_frame(32'h3333, 32'h4444, 16, 16);
        wait_clks(10);
        check("post_rst_valid", valid_cnt - v0,        32'd1);
        check("post_rst_left2", {16'h0, left_sample},  32'h3333);
        check("post_rst_right2",{16'h0, right_sample}, 32'h4444);
        check("post_rst_err",   err_cnt,               32'd2);

        // 100 random pairs at a 4:1 clock ratio with a random phase.
        half = 20;
        got_l.delete();
        got_r.delete();
        v0 = valid_cnt;
        align(int'($urandom_range(1, 4)) + 5 * int'($urandom_range(0, 1)));
        for (int i = 0; i < 100; i++) begin
            rl = 16'($urandom);
            rr = 16'($urandom);
            exp_l.push_back(rl);
            exp_r.push_back(rr);
            send_frame({16'h0, rl}, {16'h0, rr}, 16, 16);
        end
        wait_clks(20);
        half = 40;
        check("rand_valid_cnt", valid_cnt - v0,  32'd100);
        check("rand_pair_cnt",  got_l.size(),    32'd100);
        if (got_l.size() == 100) begin
            for (int i = 0; i < 100; i++)
                check($sformatf("rand_pair_%0d", i), {got_l[i], got_r[i]}, {exp_l[i], exp_r[i]});
        end

        // BCLK stopped: outputs hold and no strobes appear.
        v0 = valid_cnt;
        align(3);
        send_frame(32'h1234, 32'h5678, 16, 16);
        wait_clks(1000);
        check("stop_valid", valid_cnt - v0,        32'd1);
        check("stop_left",  {16'h0, left_sample},  32'h1234);
        check("stop_right", {16'h0, right_sample}, 32'h5678);
        check("final_err",  err_cnt,               32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- Serial-to-parallel I2S (Philips format) receiver. It is the receive end of the I2S link that the synth drives on i2s_bclk/i2s_ws/i2s_sd.
- Samples externally driven BCLK/WS/SD in the master_clk domain, deserialises left and right words, and presents them as a stereo pair with a one-cycle valid strobe.
- Uses: loopback self-test of the synth output path, and a future line-in path into the mixer.

Parameters:
- SAMPLE_WIDTH, 16, bits captured per channel word (MSB first).
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (minimum 2).

Ports:
- master_clk  input  1  system clock; must be at least 4x the BCLK frequency.
- rst  input  1  synchronous reset, active-low.
- i2s_bclk  input  1  serial bit clock, asynchronous to master_clk.
- i2s_ws  input  1  word select; 0 = left, 1 = right.
- i2s_sd  input  1  serial data, MSB first, valid on BCLK rising edge.
- left_sample  output  SAMPLE_WIDTH  last completed left word, signed.
- right_sample  output  SAMPLE_WIDTH  last completed right word, signed.
- sample_valid  output  1  one-cycle pulse: a new left/right pair is ready.
- locked  output  1  high once the first WS transition after reset has been seen.
- word_error  output  1  one-cycle pulse: a word ended with fewer than SAMPLE_WIDTH bits.

Behaviour:
- Reset (rst=0 at a master_clk edge): clear all synchroniser stages, shift register, bit counter and captured-left flag. Outputs after reset: left_sample=0, right_sample=0, sample_valid=0, locked=0, word_error=0. Reset mid-frame discards any partial word.
- Input conditioning:
  - Each of bclk, ws and sd passes through SYNC_STAGES flip-flops.
  - bclk_rise is a single-cycle pulse when the synchronised bclk goes 0->1.
  - ws and sd are sampled only on bclk_rise cycles; they share the same synchroniser depth, so the alignment is preserved.
  - Falling BCLK edges are ignored.
- Per bclk_rise, let ws_s and sd_s be the sampled values and ws_prev the ws value registered at the previous bclk_rise:
  - No WS change (ws_s == ws_prev):
    - If bit_cnt < SAMPLE_WIDTH: shift sd_s into the LSB of the shift register and increment bit_cnt.
    - Otherwise discard the bit and saturate bit_cnt. Slots wider than SAMPLE_WIDTH are legal; their extra trailing bits are dropped.
  - WS change (ws_s != ws_prev): this bit is the final bit (LSB slot) of the word for channel ws_prev.
    - Shift it in if bit_cnt < SAMPLE_WIDTH.
    - Complete the word. Let n = number of bits captured including this one.
    - If n < SAMPLE_WIDTH: left-justify the word (pad the missing LSBs with 0) and pulse word_error.
    - Clear the shift register and set bit_cnt=0. The next bclk_rise carries the MSB of the new channel (one-bit I2S delay).
- State machine:
  - UNLOCKED: all bits are discarded. On the first WS change, go to LOCKED and set locked=1. The word completed on that change is discarded, with no error pulse.
  - LOCKED:
    - Completing a left word (ws_prev=0) loads left_sample and sets the captured-left flag.
    - Completing a right word (ws_prev=1) loads right_sample. If captured-left is set, pulse sample_valid and clear captured-left.
    - A right word completed without a preceding left word updates right_sample but does not pulse sample_valid.
    - locked stays 1 until reset.
- Latency:
  - left_sample, right_sample, sample_valid and word_error are registered.
  - They update on the master_clk edge after the bclk_rise cycle that completes the word.
  - Pin-to-output latency is SYNC_STAGES+2 master_clk cycles.
- Output hold: left_sample and right_sample hold their values between completions. sample_valid is high for exactly one cycle per frame.
- BCLK stopped: no state change; outputs hold indefinitely.
- Widths: the bit counter is clog2(SAMPLE_WIDTH+1) bits wide and never wraps.

Test Plan:
- Reset then 3 frames with 32 BCLK per frame (16/16), left=16'h7FFF and right=16'h8001 -> locked=1 after first WS edge; first pair discarded; sample_valid pulses once per frame; outputs 7FFF/8001.
- Frame with 64 BCLK (32-bit slots) and left MSBs 16'hA5C3 followed by 16 bits of 1 -> left_sample=A5C3 (extras dropped); word_error never pulses.
- Short slots of 12 bits, left word 12'hABC -> left_sample=16'hABC0; word_error pulses once per short word.
- Assert rst=0 for one cycle mid-left-word, then send a valid frame -> all outputs 0 and locked=0 after reset; first post-reset pair discarded; next pair captured correctly.
- master_clk/BCLK ratio 4 with random phase, 100 random stereo pairs -> every pair matches the transmitted data; sample_valid count = 100.
- Stop BCLK for 1000 cycles after a frame with pair 1234/5678 -> outputs hold 1234/5678; no spurious sample_valid.
